// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: shift-register scoreboard of in-flight GRF writers driving stall and forward selects.
// Optional: define HAZ_EPC_STALL_EN to hold eret while an mtc0-to-EPC is still in flight.
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int TW     = 2,
  localparam int SELW  = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [4:0]      d_rs,
  input  logic [4:0]      d_rt,
  input  logic            d_rs_use,
  input  logic            d_rt_use,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic [4:0]      d_waddr,
  input  logic            d_we,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md,
  input  logic            d_start,
  input  logic            d_mtc0_epc,
  input  logic            d_eret,
  input  logic            mdu_busy,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel,
  output logic [SELW-1:0] occupancy
);

  logic [4:0]    addr_q [1:STAGES];
  logic [4:0]    addr_d [1:STAGES];
  logic [TW-1:0] tnew_q [1:STAGES];
  logic [TW-1:0] tnew_d [1:STAGES];
  logic          start_q, start_d;

  logic            rsHit, rtHit;
  logic [TW-1:0]   rsTnew, rtTnew;
  logic [SELW-1:0] rsStage, rtStage, occCount;
  logic            rsStall, rtStall, mduStall, epcStall;

`ifdef HAZ_EPC_STALL_EN
  logic [STAGES:1] epc_q, epc_d;

  always_comb begin
    epc_d = epc_q;
    if (flush) begin
      epc_d = '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        epc_d[k] = epc_q[k-1];
      end
      epc_d[1] = stall ? 1'b0 : d_mtc0_epc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q <= '0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epcStall = d_eret && (|epc_q);
`else
  logic unusedEpcInputs;
  assign unusedEpcInputs = d_mtc0_epc ^ d_eret;
  assign epcStall = 1'b0;
`endif

  // Tracked stages advance even while D is frozen; a stall only turns the E slot into a bubble.
  always_comb begin
    addr_d  = addr_q;
    tnew_d  = tnew_q;
    start_d = start_q;
    if (flush) begin
      for (int k = 1; k <= STAGES; k++) begin
        addr_d[k] = '0;
        tnew_d[k] = '0;
      end
      start_d = 1'b0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        addr_d[k] = addr_q[k-1];
        tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
      if (stall) begin
        addr_d[1] = '0;
        tnew_d[1] = '0;
        start_d   = 1'b0;
      end else begin
        addr_d[1] = d_we ? d_waddr : 5'd0;
        tnew_d[1] = d_tnew;
        start_d   = d_start;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
      start_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      tnew_q  <= tnew_d;
      start_q <= start_d;
    end
  end

  // Scan oldest to youngest so the youngest matching writer overrides older, shadowed ones.
  always_comb begin
    rsHit    = 1'b0;
    rtHit    = 1'b0;
    rsTnew   = '0;
    rtTnew   = '0;
    rsStage  = '0;
    rtStage  = '0;
    occCount = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (addr_q[k] != 5'd0) begin
        occCount = occCount + SELW'(1);
        if (addr_q[k] == d_rs) begin
          rsHit   = 1'b1;
          rsTnew  = tnew_q[k];
          rsStage = SELW'(k);
        end
        if (addr_q[k] == d_rt) begin
          rtHit   = 1'b1;
          rtTnew  = tnew_q[k];
          rtStage = SELW'(k);
        end
      end
    end
  end

  assign rsStall  = d_rs_use && rsHit && (rsTnew > d_tuse_rs);
  assign rtStall  = d_rt_use && rtHit && (rtTnew > d_tuse_rt);
  assign mduStall = d_md && (mdu_busy || start_q);
  assign stall    = rsStall || rtStall || mduStall || epcStall;

  assign fwd_rs_sel = (rsHit && rsTnew == '0) ? rsStage : '0;
  assign fwd_rt_sel = (rtHit && rtTnew == '0) ? rtStage : '0;
  assign occupancy  = occCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: queue-based pipeline model checked every cycle plus literal spot checks.
// Honours HAZ_EPC_STALL_EN so the eret expectations follow the build.
module tb_hazard_scoreboard;

  localparam int STAGES = 3;
  localparam int TW     = 2;
  localparam int SELW   = 2;
`ifdef HAZ_EPC_STALL_EN
  localparam bit EPC_EN = 1'b1;
`else
  localparam bit EPC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_waddr = '0;
  logic d_rs_use = 0, d_rt_use = 0, d_we = 0, d_md = 0, d_start = 0;
  logic d_mtc0_epc = 0, d_eret = 0, mdu_busy = 0;
  logic [TW-1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic stall;
  logic [SELW-1:0] fwd_rs_sel, fwd_rt_sel, occupancy;

  int vectors = 0;
  int miscompares = 0;
  bit cmpEn = 1'b0;

  hazard_scoreboard #(.STAGES(STAGES), .TW(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_waddr(d_waddr), .d_we(d_we), .d_tnew(d_tnew),
    .d_md(d_md), .d_start(d_start), .d_mtc0_epc(d_mtc0_epc), .d_eret(d_eret),
    .mdu_busy(mdu_busy), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .occupancy(occupancy)
  );

  always #10 clk = ~clk;

  // Model: element i is the instruction i+1 stages past D; its readiness is its entry Tnew minus its age.
  typedef struct {
    logic [4:0] addr;
    int         tnewIn;
    bit         start;
    bit         epc;
  } rec_t;
  rec_t pipe[$];

  function automatic void modelEval(output bit st, output int rsS, output int rtS, output int occ);
    bit rsF = 0, rtF = 0, anyEpc = 0;
    int rsT = 0, rtT = 0;
    rsS = 0;
    rtS = 0;
    occ = 0;
    for (int i = 0; i < pipe.size(); i++) begin
      int cur = (pipe[i].tnewIn - i < 0) ? 0 : pipe[i].tnewIn - i;
      if (pipe[i].addr != 5'd0) begin
        occ++;
        if (!rsF && pipe[i].addr == d_rs) begin
          rsF = 1; rsT = cur; rsS = (cur == 0) ? i + 1 : 0;
        end
        if (!rtF && pipe[i].addr == d_rt) begin
          rtF = 1; rtT = cur; rtS = (cur == 0) ? i + 1 : 0;
        end
      end
      if (pipe[i].epc) anyEpc = 1;
    end
    st = (d_rs_use && rsF && rsT > int'(d_tuse_rs)) ||
         (d_rt_use && rtF && rtT > int'(d_tuse_rt)) ||
         (d_md && (mdu_busy || (pipe.size() > 0 && pipe[0].start))) ||
         (EPC_EN && d_eret && anyEpc);
  endfunction

  bit   mSt;
  int   mRs, mRt, mOcc;
  rec_t mRec;

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      pipe.delete();
    end else begin
      modelEval(mSt, mRs, mRt, mOcc);
      mRec.addr   = (mSt || !d_we) ? 5'd0 : d_waddr;
      mRec.tnewIn = mSt ? 0 : int'(d_tnew);
      mRec.start  = mSt ? 1'b0 : d_start;
      mRec.epc    = (mSt || !EPC_EN) ? 1'b0 : d_mtc0_epc;
      pipe.push_front(mRec);
      if (pipe.size() > STAGES) void'(pipe.pop_back());
    end
  end

  bit cSt;
  int cRs, cRt, cOcc;

  always @(negedge clk) begin
    #2;
    if (cmpEn) begin
      modelEval(cSt, cRs, cRt, cOcc);
      vectors++;
      if (stall !== cSt || fwd_rs_sel !== SELW'(cRs) || fwd_rt_sel !== SELW'(cRt) || occupancy !== SELW'(cOcc)) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t: got stall=%b rs=%0d rt=%0d occ=%0d, want stall=%b rs=%0d rt=%0d occ=%0d",
                 $time, stall, fwd_rs_sel, fwd_rt_sel, occupancy, cSt, cRs, cRt, cOcc);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic rsU, input logic [TW-1:0] tuRs,
                               input logic [4:0] rt, input logic rtU, input logic [TW-1:0] tuRt,
                               input logic [4:0] wa, input logic we, input logic [TW-1:0] tn,
                               input logic md, input logic st, input logic busy, input logic fl,
                               input logic mtc0, input logic eret);
    @(negedge clk);
    d_rs = rs; d_rs_use = rsU; d_tuse_rs = tuRs;
    d_rt = rt; d_rt_use = rtU; d_tuse_rt = tuRt;
    d_waddr = wa; d_we = we; d_tnew = tn;
    d_md = md; d_start = st; mdu_busy = busy; flush = fl;
    d_mtc0_epc = mtc0; d_eret = eret;
    #3;
  endtask

  // Literal expectations are checked against both the DUT and the model.
  task automatic checkOutput(input string name, input logic eSt, input int eRs, input int eRt, input int eOcc);
    bit ms;
    int mr, mt, mo;
    vectors++;
    if (stall !== eSt || fwd_rs_sel !== SELW'(eRs) || fwd_rt_sel !== SELW'(eRt) || occupancy !== SELW'(eOcc)) begin
      miscompares++;
      $display("[TB] FAIL %s: got stall=%b rs=%0d rt=%0d occ=%0d, want stall=%b rs=%0d rt=%0d occ=%0d",
               name, stall, fwd_rs_sel, fwd_rt_sel, occupancy, eSt, eRs, eRt, eOcc);
    end
    modelEval(ms, mr, mt, mo);
    vectors++;
    if (ms != eSt || mr != eRs || mt != eRt || mo != eOcc) begin
      miscompares++;
      $display("[TB] FAIL %s(model): got stall=%b rs=%0d rt=%0d occ=%0d, want stall=%b rs=%0d rt=%0d occ=%0d",
               name, ms, mr, mt, mo, eSt, eRs, eRt, eOcc);
    end
  endtask

  initial begin
    cmpEn = 1'b1;
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("reset_idle", 0, 0, 0, 0);
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 1,0,1,0, 0,0);
    checkOutput("reset_mdu_comb", 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // lw $2 then dependent addu
    applyStimulus(0,0,0, 0,0,0, 2,1,2, 0,0,0,0, 0,0);
    checkOutput("lw_enter", 0, 0, 0, 0);
    applyStimulus(2,1,1, 0,0,0, 5,1,1, 0,0,0,0, 0,0);
    checkOutput("lw_use_stall", 1, 0, 0, 1);
    applyStimulus(2,1,1, 0,0,0, 5,1,1, 0,0,0,0, 0,0);
    checkOutput("lw_in_M", 0, 0, 0, 1);
    applyStimulus(2,1,1, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("lw_fwd_W", 0, 3, 0, 2);

    // ori $3 then beq $3,$5
    applyStimulus(0,0,0, 0,0,0, 3,1,1, 0,0,0,0, 0,0);
    checkOutput("ori_enter", 0, 0, 0, 1);
    applyStimulus(3,1,0, 5,1,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("beq_stall", 1, 0, 3, 2);
    applyStimulus(3,1,0, 5,1,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("beq_fwd_M", 0, 2, 0, 1);

    // shadowing: addu $4 older, lw $4 younger
    applyStimulus(0,0,0, 0,0,0, 4,1,1, 0,0,0,0, 0,0);
    checkOutput("addu4", 0, 0, 0, 1);
    applyStimulus(0,0,0, 0,0,0, 4,1,2, 0,0,0,0, 0,0);
    checkOutput("lw4", 0, 0, 0, 1);
    applyStimulus(4,1,1, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("shadow_stall", 1, 0, 0, 2);
    applyStimulus(4,1,1, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("shadow_nofwd", 0, 0, 0, 2);
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("drain", 0, 0, 0, 1);

    // mult then mflo under MDU busy
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 1,1,0,0, 0,0);
    checkOutput("mult", 0, 0, 0, 0);
    applyStimulus(0,0,0, 0,0,0, 8,1,1, 1,0,0,0, 0,0);
    checkOutput("mflo_start", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0,0,0, 0,0,0, 8,1,1, 1,0,1,0, 0,0);
      checkOutput("mflo_busy", 1, 0, 0, 0);
    end
    applyStimulus(0,0,0, 0,0,0, 8,1,1, 1,0,0,0, 0,0);
    checkOutput("mflo_go", 0, 0, 0, 0);

    // fill, then flush together with stall
    applyStimulus(0,0,0, 0,0,0, 9,1,2, 0,0,0,0, 0,0);
    checkOutput("fill1", 0, 0, 0, 1);
    applyStimulus(0,0,0, 0,0,0, 10,1,1, 0,0,0,0, 0,0);
    checkOutput("fill2", 0, 0, 0, 2);
    applyStimulus(10,1,0, 0,0,0, 11,1,2, 0,0,0,1, 0,0);
    checkOutput("full_flush_stall", 1, 0, 0, 3);
    applyStimulus(10,1,0, 0,0,0, 11,1,2, 0,0,0,0, 0,0);
    checkOutput("after_flush", 0, 0, 0, 0);
    applyStimulus(11,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("pre_reset_stall", 1, 0, 0, 1);
    #1 reset = 1'b1;
    #2 checkOutput("mid_reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // mtc0 EPC followed by eret
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 1,0);
    checkOutput("mtc0_epc", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,1);
      checkOutput("eret_wait", EPC_EN, 0, 0, 0);
    end
    applyStimulus(0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,1);
    checkOutput("eret_go", 0, 0, 0, 0);

    // write to $0 is a bubble
    applyStimulus(0,0,0, 0,0,0, 0,1,0, 0,0,0,0, 0,0);
    checkOutput("we_zero", 0, 0, 0, 0);
    applyStimulus(0,1,0, 0,1,0, 0,0,0, 0,0,0,0, 0,0);
    checkOutput("read_zero", 0, 0, 0, 0);

    @(negedge clk);
    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined MIPS core, placed beside the D-stage decoder.
- Keeps a shift-register scoreboard of in-flight GRF writers (address plus Tnew) for the STAGES stages after D.
- From each D-stage instruction's Tuse/Tnew it drives the D-stage stall and the D-stage forwarding selects.
- Covers the MDU-busy stall for mult/div/mf/mt instructions, and drains or flushes on exception.

Parameters:
STAGES, 3, number of tracked stages after D (1=E, 2=M, 3=W); legal range 2..7
TW, 2, width of Tuse/Tnew fields
SELW, derived localparam = clog2(STAGES+1), width of forward select

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears scoreboard
flush  in  1  synchronous; exception/eret flush of all tracked stages
d_rs  in  5  D-stage rs address
d_rt  in  5  D-stage rt address
d_rs_use  in  1  D instruction reads rs
d_rt_use  in  1  D instruction reads rt
d_tuse_rs  in  TW  cycles until rs needed (0 = needed in D)
d_tuse_rt  in  TW  cycles until rt needed
d_waddr  in  5  D instruction GRF destination
d_we  in  1  D instruction writes GRF
d_tnew  in  TW  cycles after entering E until result forwardable
d_md  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
d_start  in  1  D instruction starts MDU (mult/multu/div/divu)
d_mtc0_epc  in  1  D instruction is mtc0 to CP0 reg 14 (used only with the optional feature)
d_eret  in  1  D instruction is eret (used only with the optional feature)
mdu_busy  in  1  MDU busy from E stage
stall  out  1  freeze PC/F/D and insert bubble into E
fwd_rs_sel  out  SELW  0 = GRF, k = forward from stage k
fwd_rt_sel  out  SELW  as above for rt
occupancy  out  SELW  number of valid writer entries, for debug

Behaviour:
- State: entry[k], k=1..STAGES, each holding addr[4:0], tnew[TW-1:0], start (start used by entry[1] only), epc (used only with the optional feature).
- An entry is valid when addr != 0.
- Reset (asynchronous): all entries cleared to addr=0, tnew=0, start=0, epc=0. occupancy=0, fwd selects=0.
- stall=0 at reset, except through the MDU term (d_md && mdu_busy), which is purely combinational.
- Each rising edge, priority order:
  - flush: all entries cleared.
  - else stall: entry[1] gets a bubble (all zero).
  - else entry[1] <= {d_we ? d_waddr : 0, d_tnew, d_start, d_mtc0_epc}.
- In every non-flush cycle, entry[k+1] <= entry[k] with tnew = (tnew==0) ? 0 : tnew-1. Decrement saturates at 0; entry[STAGES] drops off.
- The tracked stages keep advancing during a stall; only D is frozen.
- Match rule: for source s (rs or rt), only the youngest valid entry k with addr==s counts. Older matches are shadowed. s==0 never matches.
- Data-hazard stall term: use_s && youngest match exists && match.tnew > tuse_s.
- MDU stall term: d_md && (mdu_busy || entry[1].start).
- stall = OR of the rs, rt and MDU terms (plus the EPC term with the optional feature). Combinational; no added latency.
- fwd_s_sel = k when the youngest match has tnew==0; otherwise 0. Downstream stages forward later-ready data themselves.
- occupancy = count of valid entries.
- Boundaries:
  - d_waddr=0 with d_we=1 is stored as a bubble.
  - flush together with stall: flush wins, entries cleared, no D capture.
  - reset mid-stall: stall terms from entries drop immediately.
  - All entries valid: no overflow; depth is fixed.

Optional Feature:
- Macro: HAZ_EPC_STALL_EN.
- Defined:
  - Each entry carries the epc bit.
  - stall also asserts when d_eret && any entry has epc=1, so eret waits for an in-flight mtc0 to EPC to commit.
- Undefined:
  - The epc bits are absent and d_mtc0_epc/d_eret are ignored.
  - eret relies on CP0-side EPC forwarding.

Test Plan:
1. lw $2 (tnew=2) enters E; next D is addu reading $2 with tuse_rs=1. Expect stall=1 for exactly 1 cycle. Then fwd_rs_sel=0 while the lw is in M (tnew=1); once it reaches W, sel=3 (tnew=0).
2. ori $3 (tnew=1) in E, then beq using $3 with tuse=0. Expect stall=1 for 1 cycle, then fwd_rs_sel=2 (M, tnew=0).
3. Shadowing: addu $4 in M (tnew=0) and lw $4 in E (tnew=2); D reads $4 with tuse=1. Expect stall=1 (younger lw wins), not a forward from M.
4. mult in E (entry[1].start=1) with mflo in D. Expect stall=1. While mdu_busy=1 for 5 cycles, stall stays high; it falls the cycle mdu_busy falls.
5. Fill all 3 entries, then assert flush together with stall. Next cycle occupancy=0 and stall=0. Assert reset mid-sequence: all entries cleared asynchronously.
6. With HAZ_EPC_STALL_EN: mtc0 EPC in E, eret in D. Expect stall=1 for 3 cycles until the entry exits W. Without the macro, stall=0.
